// File: rtl/uart_baud_gen.sv
// Fractional-N baud enable generator: a phase accumulator steps by BAUD_RATE each cycle and
// wraps modulo BAUD_CLOCK_SPEED, emitting a one-cycle enable on every wrap.
module uart_baud_gen #(
  parameter int unsigned BAUD_CLOCK_SPEED = 2000000,
  parameter int unsigned BAUD_RATE        = 2000000,
  parameter int unsigned DELAY            = 0
) (
  input  logic uart_clk,
  input  logic uart_rst,
  input  logic uart_hold,
  output logic uart_ena
);

  localparam int unsigned AccW = $clog2(BAUD_CLOCK_SPEED + BAUD_RATE) + 1;

  localparam longint unsigned HoldLoadWide = 64'(DELAY) * 64'(BAUD_RATE);

  localparam logic [AccW-1:0] Inc      = AccW'(BAUD_RATE);
  localparam logic [AccW-1:0] Modulus  = AccW'(BAUD_CLOCK_SPEED);
  localparam logic [AccW-1:0] HoldLoad = AccW'(HoldLoadWide);

  if (!(BAUD_RATE > 0 && BAUD_RATE <= BAUD_CLOCK_SPEED &&
        HoldLoadWide < 64'(BAUD_CLOCK_SPEED))) begin : gen_param_check
    $error("uart_baud_gen: need 0 < BAUD_RATE <= BAUD_CLOCK_SPEED and DELAY*BAUD_RATE < BAUD_CLOCK_SPEED");
  end

  logic [AccW-1:0] acc_q, acc_d;
  logic            ena_q, ena_d;
  logic [AccW-1:0] sum;
  logic            wrap;

  // acc_q stays below Modulus, so sum never exceeds Modulus + Inc and fits AccW bits.
  always_comb begin
    sum   = acc_q + Inc;
    wrap  = (sum >= Modulus);
    acc_d = wrap ? (sum - Modulus) : sum;
    ena_d = wrap;
  end

  // Reset wins over hold; hold discards any pending wrap and reloads the start phase.
  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      acc_q <= '0;
      ena_q <= 1'b0;
    end else if (uart_hold) begin
      acc_q <= HoldLoad;
      ena_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ena_q <= ena_d;
    end
  end

  assign uart_ena = ena_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed checks of uart_baud_gen over four parameter sets sharing one clock, reset and hold.
module tb_uart_baud_gen;

  logic clk = 1'b0;
  logic rst;
  logic hold;
  logic ena_a, ena_b, ena_c, ena_d;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  uart_baud_gen #(.BAUD_CLOCK_SPEED(16), .BAUD_RATE(4), .DELAY(0)) dut_a (
    .uart_clk(clk), .uart_rst(rst), .uart_hold(hold), .uart_ena(ena_a)
  );
  uart_baud_gen #(.BAUD_CLOCK_SPEED(10), .BAUD_RATE(3), .DELAY(0)) dut_b (
    .uart_clk(clk), .uart_rst(rst), .uart_hold(hold), .uart_ena(ena_b)
  );
  uart_baud_gen #(.BAUD_CLOCK_SPEED(10000000), .BAUD_RATE(912600), .DELAY(0)) dut_c (
    .uart_clk(clk), .uart_rst(rst), .uart_hold(hold), .uart_ena(ena_c)
  );
  uart_baud_gen #(.BAUD_CLOCK_SPEED(16), .BAUD_RATE(4), .DELAY(2)) dut_d (
    .uart_clk(clk), .uart_rst(rst), .uart_hold(hold), .uart_ena(ena_d)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int b_acc [10] = '{3, 6, 9, 2, 5, 8, 1, 4, 7, 0};
  int b_ena [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    int pulses, last, bad_int, back2back, prev;
    int v_hold, v_b2b, v_acc;
    logic h;

    rst  = 1'b1;
    hold = 1'b0;
    tick();
    tick();
    check_eq("rst_ena_a", ena_a, 0);
    check_eq("rst_acc_a", dut_a.acc_q, 0);
    check_eq("rst_acc_b", dut_b.acc_q, 0);
    check_eq("rst_acc_d", dut_d.acc_q, 0);
    check_eq("rst_ena_c", ena_c, 0);

    // After reset every instance, including DELAY=2, starts from phase 0.
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_eq($sformatf("a16_4_ena_e%0d", k), ena_a, (k % 4 == 0) ? 1 : 0);
      check_eq($sformatf("d_after_rst_ena_e%0d", k), ena_d, (k % 4 == 0) ? 1 : 0);
      check_eq($sformatf("b10_3_acc_e%0d", k), dut_b.acc_q, b_acc[k-1]);
      check_eq($sformatf("b10_3_ena_e%0d", k), ena_b, b_ena[k-1]);
    end

    hold = 1'b1;
    tick();
    check_eq("hold_acc_d", dut_d.acc_q, 8);
    check_eq("hold_acc_a", dut_a.acc_q, 0);
    check_eq("hold_ena_a", ena_a, 0);
    check_eq("hold_ena_d", ena_d, 0);
    tick();
    check_eq("hold2_acc_d", dut_d.acc_q, 8);

    hold = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_eq($sformatf("delay2_ena_e%0d", k), ena_d, (k % 4 == 2) ? 1 : 0);
      check_eq($sformatf("a_rel_ena_e%0d", k), ena_a, (k % 4 == 0) ? 1 : 0);
    end

    // Hold lands on the edge that would have pulsed: the pulse is dropped.
    tick();
    tick();
    tick();
    check_eq("a_pre_hold_acc", dut_a.acc_q, 12);
    hold = 1'b1;
    tick();
    check_eq("a_midhold_ena", ena_a, 0);
    check_eq("a_midhold_acc", dut_a.acc_q, 0);
    hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq($sformatf("a_rehold_ena_e%0d", k), ena_a, (k == 4) ? 1 : 0);
    end

    rst  = 1'b1;
    hold = 1'b1;
    tick();
    check_eq("rst_hold_acc_d", dut_d.acc_q, 0);
    check_eq("rst_hold_ena_d", ena_d, 0);
    check_eq("rst_hold_acc_b", dut_b.acc_q, 0);
    rst  = 1'b0;
    hold = 1'b0;
    tick();
    tick();
    check_eq("b_mid_acc", dut_b.acc_q, 6);
    rst = 1'b1;
    tick();
    check_eq("b_midrst_acc", dut_b.acc_q, 0);
    check_eq("b_midrst_ena", ena_b, 0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq($sformatf("b_rst_rel_ena_e%0d", k), ena_b, (k == 4) ? 1 : 0);
    end

    // 40000 cycles at 10 MHz / 912600 Hz: floor(40000*0.09126) = 3650 pulses.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    pulses    = 0;
    last      = 0;
    bad_int   = 0;
    back2back = 0;
    prev      = 0;
    for (int k = 1; k <= 40000; k++) begin
      tick();
      if (ena_c) begin
        pulses++;
        if ((k - last) < 10 || (k - last) > 11) bad_int++;
        if (prev != 0) back2back++;
        last = k;
      end
      prev = ena_c ? 1 : 0;
    end
    check_eq("c_pulse_count", pulses, 3650);
    check_eq("c_bad_intervals", bad_int, 0);
    check_eq("c_back_to_back", back2back, 0);

    v_hold = 0;
    v_b2b  = 0;
    v_acc  = 0;
    prev   = 0;
    for (int k = 0; k < 3000; k++) begin
      h    = 1'($urandom_range(0, 1));
      hold = h;
      tick();
      if (h && ena_c) v_hold++;
      if (ena_c && prev != 0) v_b2b++;
      if (longint'(dut_c.acc_q) >= 10000000) v_acc++;
      prev = ena_c ? 1 : 0;
    end
    hold = 1'b0;
    check_eq("rnd_pulse_while_held", v_hold, 0);
    check_eq("rnd_back_to_back", v_b2b, 0);
    check_eq("rnd_acc_overrange", v_acc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
